// File: rtl/cla_chunk_seq.sv
// Multi-cycle W*K-bit adder/subtractor: one W-bit carry-lookahead slice is
// stepped across K chunks, LSB first, with the carry registered between chunks.
module cla_chunk_seq #(
  parameter int unsigned W = 8,
  parameter int unsigned K = 4
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           in_valid_i,
  output logic           in_ready_o,
  input  logic [W*K-1:0] a_i,
  input  logic [W*K-1:0] b_i,
  input  logic           cin_i,
  input  logic           sub_i,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic [W*K-1:0] sum_o,
  output logic           cout_o,
  output logic           ovf_o
);

  localparam int unsigned N       = W * K;
  localparam int unsigned IdxW    = (K > 1) ? $clog2(K) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(K - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [W-1:0]    a_chunk, b_chunk, s_chunk;
  logic            c_top, c_msb;

  assign a_chunk = W'(a_q >> (32'(idx_q) * W));
  assign b_chunk = W'(b_q >> (32'(idx_q) * W));

  always_comb begin : slice
    logic [W:0]   c;
    logic [W-1:0] g, p;
    g    = a_chunk & b_chunk;
    p    = a_chunk ^ b_chunk;
    c    = '0;
    c[0] = carry_q;
    for (int j = 0; j < W; j++) begin
      c[j+1] = g[j] | (p[j] & c[j]);
    end
    s_chunk = p ^ c[W-1:0];
    c_top   = c[W];
    c_msb   = c[W-1];
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          // Subtraction is A + ~B + 1; cin only matters for addition.
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          carry_d = sub_i ? 1'b1 : cin_i;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int k = 0; k < K; k++) begin
          if (idx_q == IdxW'(k)) sum_d[k*W +: W] = s_chunk;
        end
        carry_d = c_top;
        if (idx_q == IdxLast) begin
          cout_d  = c_top;
          ovf_d   = c_top ^ c_msb;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign sum_o       = sum_q;
  assign cout_o      = cout_q;
  assign ovf_o       = ovf_q;

endmodule

// File: doc/cla_chunk_seq.md
Name: cla_chunk_seq

Overview:
- Multi-cycle wide adder/subtractor controller.
- Accepts one W*K-bit operation over a valid/ready handshake and sequences a W-bit carry-lookahead slice across K chunks, one chunk per cycle, LSB chunk first. The carry is registered between chunks.
- Presents the result on a held valid/ready output. Used where a full-width single-cycle lookahead is too large or too slow.

Parameters:
- W, 8, chunk width in bits processed per cycle (>=1).
- K, 4, number of chunks; operand width is W*K (>=1).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation (IDLE only).
- a  input  W*K  operand A.
- b  input  W*K  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1 = compute A - B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- sum  output  W*K  result bits.
- cout  output  1  carry out of the MSB. For sub, 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset, asynchronous, any state: FSM=IDLE, chunk index=0, carry reg=0, out_valid=0, sum=0, cout=0, ovf=0. in_ready=1 once in IDLE.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready at a clock edge: latch a into A_r.
  - If sub=1, latch ~b into B_r and set carry reg to 1 (cin ignored). If sub=0, latch b into B_r and set carry reg to cin.
  - Set idx=0 and go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle, slice chunk idx (bits idx*W+W-1 : idx*W) of A_r and B_r.
  - Form per-bit generate g=a&b and propagate p=a^b. Compute the slice carries combinationally by lookahead: c[0]=carry reg, c[j+1]=g[j] | (p[j] & c[j]).
  - sum chunk = p ^ c[W-1:0].
  - At the edge, write the sum chunk into the sum register and load c[W] into carry reg.
  - If idx==K-1: also capture cout=c[W] and ovf=c[W]^c[W-1] (from the MSB slice), then go to DONE. Otherwise idx<=idx+1.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable while out_valid=1 and out_ready=0.
  - On out_valid&&out_ready at an edge: go to IDLE. in_ready=1 in the next cycle.
  - No same-cycle re-accept.
- Latency: accept edge at cycle t, out_valid high from cycle t+K.
  - Minimum initiation interval is K+2 cycles (accept, K RUN edges, DONE handshake, IDLE accept).
- in_valid while not IDLE is ignored. Operand inputs are sampled only at the accept edge; later changes have no effect.
- sum, cout and ovf are meaningful only while out_valid=1. In RUN, the sum register holds partially updated chunks.
- Arithmetic: sum = (A + B_eff + carry0) mod 2^(W*K), with B_eff and carry0 as latched in IDLE. All widths are unsigned internally; ovf uses the signed interpretation.
- K=1 is legal: RUN lasts exactly one cycle. idx counter width is max(1, clog2(K)).
- Reset mid-RUN or mid-DONE: the operation is discarded with no out_valid pulse. The next operation after reset release must be correct.
- out_ready high while out_valid=0 has no effect.

Test Plan (W=8, K=4):
- a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0, accept at t -> out_valid first high at t+4; sum=0x00000000, cout=1, ovf=0.
- a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1. Then a=0x12345678, b=0x0000FF88, cin=1 -> sum=0x12355601, cout=0, ovf=0.
- sub=1, a=5, b=7, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0. Then sub=1, a=0x80000000, b=1 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
  - Required: sum/cout/ovf stable, in_ready=0, new operands not taken.
  - After the out_ready handshake: in_ready=1 next cycle, and the new op is accepted then.
- Reset: assert rst asynchronously (between edges) two cycles into RUN.
  - Required: out_valid=0, sum=0, cout=0 immediately; in_ready=1 after release.
  - No stale out_valid pulse.
  - The next op a=3, b=4 gives sum=7, cout=0.
- Random regression, 10k ops with random sub/cin and random in_valid/out_ready gaps:
  - Every result matches the reference model (sum, cout, ovf).
  - Back-to-back spacing is exactly K+2 cycles when in_valid and out_ready are held high.
  - Repeat with K=1, W=8 and with K=3, W=5.
